if_stage: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the

---
 rtl/mips_pkg.sv | 28 ++
 rtl/if_stage_if.sv | 10 +
 rtl/if_id_reg.sv | 35 +++
 rtl/if_stage.sv | 87 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, bubble encoding and IF/ID record type.
package mips_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    typedef enum logic [1:0] {
        IFID_LOAD  = 2'd0,
        IFID_HOLD  = 2'd1,
        IFID_FLUSH = 2'd2
    } ifid_ctl_e;

    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.instr    = NOP_INSTR;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus: fetch address out, combinational instruction word back.
interface if_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new entry, hold it, or flush to a bubble; resets to a bubble.
module if_id_reg
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  ifid_ctl_e ctl,
    input  ifid_t     ifid_in,
    output ifid_t     ifid_out
);

    ifid_t ifid_d;
    ifid_t ifid_q;

    always_comb begin
        ifid_d = ifid_q;
        unique case (ctl)
            IFID_LOAD:  ifid_d = ifid_in;
            IFID_HOLD:  ifid_d = ifid_q;
            IFID_FLUSH: ifid_d = ifid_bubble();
            default:    ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_q <= ifid_bubble();
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_out = ifid_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, fetch counter and misalignment flag.
module if_stage
    import mips_pkg::*;
#(
    parameter int unsigned     XLEN      = mips_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int unsigned     CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  start_pc,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [XLEN-1:0]  redirect_target,
    if_stage_if.master       imem,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  ifid_instr,
    output logic [XLEN-1:0]  ifid_pc_plus4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] fetch_count,
    output logic             misalign_err
);

    logic [XLEN-1:0]  pc_d, pc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             misalign_d, misalign_q;
    logic [XLEN-1:0]  pc_plus4;
    ifid_ctl_e        ifid_ctl;
    ifid_t            ifid_next;
    ifid_t            ifid_cur;

    assign pc_plus4 = pc_q + PC_STEP;

    // Redirect outranks stall: a taken branch must flush even while decode is stalled.
    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        misalign_d = misalign_q;
        ifid_ctl   = IFID_HOLD;
        if (redirect_en) begin
            pc_d     = {redirect_target[XLEN-1:2], 2'b00};
            ifid_ctl = IFID_FLUSH;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d     = pc_plus4;
            cnt_d    = cnt_q + CNT_W'(1);
            ifid_ctl = IFID_LOAD;
        end
    end

    always_comb begin
        ifid_next.instr    = imem.imem_rdata;
        ifid_next.pc_plus4 = pc_plus4;
        ifid_next.valid    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= start_pc;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctl      (ifid_ctl),
        .ifid_in  (ifid_next),
        .ifid_out (ifid_cur)
    );

    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign ifid_instr     = ifid_cur.instr;
    assign ifid_pc_plus4  = ifid_cur.pc_plus4;
    assign ifid_valid     = ifid_cur.valid;
    assign fetch_count    = cnt_q;
    assign misalign_err   = misalign_q;

endmodule
